// File: rtl/spi_slave_param_if.sv
// rtl/spi_slave_param_if.sv - SPI pin and word-handshake bundle for spi_slave_param
interface spi_slave_param_if #(
  parameter int WIDTH = 8
);
  logic             SCK;
  logic             SSEL;
  logic             MOSI;
  logic             MISO;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             busy;

  modport slave (
    input  SCK, SSEL, MOSI, tx_data, tx_valid,
    output MISO, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output SCK, SSEL, MOSI, tx_data, tx_valid,
    input  MISO, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - oversampled SPI slave, configurable width/mode/bit order
// with a valid/ready transmit holding register and a one-cycle receive strobe.
module spi_slave_param #(
  parameter int WIDTH     = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_param_if.slave bus
);
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic          SCK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {S_ARM, S_IDLE, S_FRAME} state_t;

  state_t           r_state;
  logic [2:0]       r_sck_sync;
  logic [2:0]       r_ssel_sync;
  logic [1:0]       r_mosi_sync;
  logic [1:0]       r_arm_cnt;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_rx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_rx_valid;
  logic             r_tx_underrun;
  logic             r_tx_ready;
  logic             r_miso_oe;

  logic             w_sck_rise, w_sck_fall, w_lead, w_trail;
  logic             w_sample_edge, w_shift_edge;
  logic             w_ssel_fall, w_ssel_rise;
  logic             w_mosi, w_in_frame, w_load, w_shift;
  logic [WIDTH-1:0] w_rx_next;

  assign w_sck_rise    = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall    = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_lead        = SCK_IDLE ? w_sck_fall : w_sck_rise;
  assign w_trail       = SCK_IDLE ? w_sck_rise : w_sck_fall;
  assign w_sample_edge = (CPHA != 0) ? w_trail : w_lead;
  assign w_shift_edge  = (CPHA != 0) ? w_lead : w_trail;
  assign w_ssel_fall   = ~r_ssel_sync[1] & r_ssel_sync[2];
  assign w_ssel_rise   = r_ssel_sync[1] & ~r_ssel_sync[2];
  assign w_mosi        = r_mosi_sync[1];
  assign w_in_frame    = (r_state == S_FRAME) && !w_ssel_rise;

  assign w_rx_next = (MSB_FIRST != 0) ? {r_rx_shift[WIDTH-2:0], w_mosi}
                                      : {w_mosi, r_rx_shift[WIDTH-1:1]};

  // A shift edge at counter 0 always starts a new word; CPHA=0 also loads at frame start.
  assign w_load  = ((r_state == S_IDLE) && w_ssel_fall && (CPHA == 0)) ||
                   (w_in_frame && w_shift_edge && (r_bit_cnt == '0));
  assign w_shift = w_in_frame && w_shift_edge && (r_bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_ARM;
      r_sck_sync    <= {3{SCK_IDLE}};
      r_ssel_sync   <= 3'b111;
      r_mosi_sync   <= 2'b00;
      r_arm_cnt     <= 2'd0;
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_tx_shift    <= '0;
      r_hold        <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_tx_ready    <= 1'b1;
      r_miso_oe     <= 1'b0;
    end else begin
      r_sck_sync    <= {r_sck_sync[1:0], bus.SCK};
      r_ssel_sync   <= {r_ssel_sync[1:0], bus.SSEL};
      r_mosi_sync   <= {r_mosi_sync[0], bus.MOSI};
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;

      case (r_state)
        // Wait until the chain holds only post-reset samples of an inactive SSEL.
        S_ARM: begin
          if (r_arm_cnt != 2'd3) begin
            r_arm_cnt <= r_arm_cnt + 2'd1;
          end else if (&r_ssel_sync) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_ssel_fall) begin
            r_state   <= S_FRAME;
            r_miso_oe <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        S_FRAME: begin
          if (w_ssel_rise) begin
            r_state    <= S_IDLE;
            r_miso_oe  <= 1'b0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
          end else if (w_sample_edge) begin
            r_rx_shift <= w_rx_next;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt  <= '0;
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_ARM;
      endcase

      if (w_load) begin
        r_tx_shift    <= r_tx_ready ? '0 : r_hold;
        r_tx_underrun <= r_tx_ready;
        r_tx_ready    <= 1'b1;
      end else if (w_shift) begin
        r_tx_shift <= (MSB_FIRST != 0) ? {r_tx_shift[WIDTH-2:0], 1'b0}
                                       : {1'b0, r_tx_shift[WIDTH-1:1]};
      end

      // Accept is judged on the pre-cycle holding state, so it lands after any load.
      if (bus.tx_valid && r_tx_ready) begin
        r_hold     <= bus.tx_data;
        r_tx_ready <= 1'b0;
      end
    end
  end

  assign bus.MISO        = (MSB_FIRST != 0) ? r_tx_shift[WIDTH-1] : r_tx_shift[0];
  assign bus.miso_oe     = r_miso_oe;
  assign bus.busy        = r_miso_oe;
  assign bus.tx_ready    = r_tx_ready;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_tx_underrun;
endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave: the next-generation successor to the team's fixed 8-bit, mode-0 SPI slave. Oversamples SCK/SSEL/MOSI on the system clock and supports configurable word width, all four CPOL/CPHA modes and bit order. Adds a valid/ready transmit holding register and a one-cycle receive strobe. It sits between an external SPI master and on-chip register/command logic.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 2..32, need not be a power of two
- CPOL, 0, SCK idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- MSB_FIRST, 1, 1 = MSB first on both lines, 0 = LSB first

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous reset, active-high
- SCK  in  1  SPI clock, asynchronous to clk
- SSEL  in  1  slave select, active-low, asynchronous
- MOSI  in  1  serial data in, asynchronous
- MISO  out  1  serial data out
- miso_oe  out  1  high while the synchronised SSEL is active; drives an external tri-state buffer
- tx_data  in  WIDTH  next word to transmit
- tx_valid  in  1  tx_data is offered
- tx_ready  out  1  holding register is empty
- rx_data  out  WIDTH  last complete received word
- rx_valid  out  1  one-cycle strobe: rx_data has been updated
- tx_underrun  out  1  one-cycle strobe: a word load found the holding register empty
- busy  out  1  frame in progress (equals miso_oe)

## Operation
- **Synchronisers.** SCK and SSEL each pass through a 3-flop chain; edges are detected on stages [2:1]. MOSI passes through a 2-flop chain.
- **Edge classification.** The leading edge is the idle-to-active SCK transition: rising when CPOL=0, falling when CPOL=1.
  - Sample edge = leading edge if CPHA=0, otherwise trailing edge.
  - Shift edge = the opposite edge.
- **Frame.** A frame starts on a synchronised SSEL falling edge and ends on its rising edge.
  - While SSEL is inactive, the bit counter is held at 0 and SCK edges are ignored.
- **Bit counter.** Width is $clog2(WIDTH). It increments on each sample edge and wraps from WIDTH-1 to 0.
- **RX.** On each sample edge, MOSI is shifted into the rx shift register: into the LSB, shifting left, when MSB_FIRST=1; into the MSB, shifting right, when MSB_FIRST=0.
  - On the sample edge where the counter equals WIDTH-1, the assembled word is copied to rx_data and rx_valid pulses for one cycle.
  - There is no backpressure. rx_data holds its value until the next complete word.
- **TX holding register.** tx_ready = holding register empty. A word is accepted when tx_valid && tx_ready; tx_ready then goes low.
- **Word-load points.**
  - CPHA=0: at frame start, and at the shift edge that follows the WIDTH-th sample.
  - CPHA=1: at every shift edge where the counter is 0.
- **Load and shift.** At a load point the tx shift register takes the holding register and the holding register becomes empty.
  - If the holding register is empty, the shift register loads all zeros and tx_underrun pulses.
  - All other shift edges shift the tx register one place toward the output bit, filling with 0.
- **MISO.** MISO = tx_shift[WIDTH-1] when MSB_FIRST=1, else tx_shift[0].
- **Simultaneous accept and load.** If a word is accepted in the same cycle as a load, the load uses the holding state from before that cycle. The newly accepted word stays in the holding register for the next load.
- **Abort.** SSEL deasserted mid-word:
  - the partial rx word is discarded and no rx_valid is generated;
  - the counter returns to 0;
  - the holding register keeps any unconsumed word.
- **Reset values.** MISO=0, miso_oe=0, busy=0, rx_data=0, rx_valid=0, tx_underrun=0, tx_ready=1. All shift registers, the holding register and the counter are cleared. Synchroniser flops reset to the idle levels (SCK=CPOL, SSEL=1, MOSI=0).
- **Reset mid-frame.** The frame is dropped with no strobes. After reset releases, SSEL must be seen inactive (high) before a new frame is recognised.

## Timing
- Pin-to-detect latency: 3 clk for SCK and SSEL edges. MOSI is sampled from its 2-stage output in the same cycle the SCK edge is detected.
- rx_valid asserts exactly 1 clk after the detected final sample edge.
- MISO changes 1 clk after a detected shift edge or frame start, i.e. 4 clk after the pin edge.
- Requirement: each SCK high and low phase lasts ≥ 4 clk. For CPHA=0, the first leading edge comes ≥ 4 clk after SSEL falls.
- tx_ready rises 1 clk after a load that emptied the holding register.
- Back-to-back words within one frame need no gap. Multiple words per frame are unlimited.

## Test plan
- **Mode 0, WIDTH=8, MSB first.** tx 0xA5 preloaded; master sends 0x3C. MISO bits read 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; tx_ready returns to 1.
- **Mode 3, WIDTH=12, LSB first.** Two back-to-back words in one frame: master sends 0x123 then 0xABC; tx 0x5F0 then 0x00F. Master receives both tx words; two rx_valid pulses with 0x123 and 0xABC.
- **Underrun, mode 1.** Holding register empty at frame start. tx_underrun pulses once at the first leading edge; master reads 0x00.
- **Abort.** SSEL rises after 5 of 8 bits. No rx_valid; counter back to 0. The next full frame receives its word correctly, with no stale bits.
- **Accept on the load cycle.** tx_valid asserted (tx 0x77) in the exact cycle of the second word's load, with the holding register empty. The second word transmits 0x00 and tx_underrun pulses; the third word transmits 0x77.
- **Reset mid-frame.** rst pulsed during bit 3. All outputs return to their reset values and no strobes occur; after SSEL toggles high then low, a frame sending 0x81 is received correctly.
